vga_clk_rng: RTL and testbench
==============================

# vga_clk_rng

Clock and pseudo-random source for the VGA maze display. From the 100 MHz board clock it produces:
- a 25 MHz pixel clock for the VGA timing generator;
- a slow divided clock used for display and scan timing;
- a maximal-length XNOR LFSR that steps once per divided-clock period and supplies random wall-enable bits.

All logic is in the single `in_clk` domain.

## Interface
Parameters:
- `DIV_NUMBER`, default 50000. Half-period of `div_clk`, counted in `in_clk` cycles. Must be ≥ 1.
- `PIX_HALF`, default 2. Half-period of `clk_pix` in `in_clk` cycles, giving 100 MHz → 25 MHz.
- `NUM_BITS`, default 25. LFSR width. Supported range is 3..32.
- `SEED`, default 30504031. Documentation default for the `i_seed_data` tie-off. It does not affect reset.

Ports:
- `in_clk` — input, 1 bit. Sole clock; all state updates on its rising edge.
- `reset` — input, 1 bit. Asynchronous, active-high.
- `i_enable` — input, 1 bit. Gates LFSR stepping and seed loading.
- `i_seed_dv` — input, 1 bit. Seed-load request.
- `i_seed_data` — input, `NUM_BITS` bits. Seed value; also the comparison value for `o_lfsr_done`.
- `clk_pix` — output, 1 bit. Registered pixel clock, 50 % duty.
- `div_clk` — output, 1 bit. Registered divided clock, 50 % duty.
- `o_lfsr_data` — output, `NUM_BITS` bits. Current LFSR state.
- `o_lfsr_done` — output, 1 bit. Combinational; high while `o_lfsr_data == i_seed_data`.

## Operation
- **Divider.** Counter `cnt` increments every cycle.
  - When `cnt == DIV_NUMBER-1`: `cnt` returns to 0 and `div_clk` toggles.
  - Result: `div_clk` period is `2*DIV_NUMBER` cycles.
- **Pixel clock.** Identical scheme with `PIX_HALF`, giving a period of `2*PIX_HALF` cycles.
- **Step enable.** `step = (cnt == DIV_NUMBER-1) && !div_clk`. It is a single-cycle pulse on the cycle before each `div_clk` rising edge.
- **LFSR.** Fibonacci, XNOR feedback, 1-indexed taps from the standard maximal-length table. Required entries:
  - width 4: taps 4,3
  - width 8: taps 8,6,5,4
  - width 16: taps 16,15,13,4
  - width 25: taps 25,22
  - all other widths from 3..32 per the table.
- **LFSR update priority** (highest first):
  - `i_enable && i_seed_dv`: load `i_seed_data` on the next edge, independent of `step`.
  - `i_enable && step`: shift, `r <= {r[NUM_BITS-2:0], fb}`, where `fb` = XNOR of the tap bits.
  - otherwise: hold.
- **Lock-up state.** The all-ones state is the XNOR lock-up state. The block does not escape it; loading all ones as a seed freezes the LFSR.
- **Period.** From any non-lock-up state the sequence period is `2^NUM_BITS − 1` steps.

## Timing
- **Reset values.** `cnt` = 0, pixel counter = 0, `clk_pix` = 0, `div_clk` = 0, LFSR = 0.
  - `o_lfsr_done` = 1 if and only if `i_seed_data == 0`.
- **After reset release:**
  - First `div_clk` rise is at the `DIV_NUMBER`-th rising edge of `in_clk`.
  - First `clk_pix` rise is at the `PIX_HALF`-th rising edge.
- **Step alignment.** The LFSR update lands on the same edge as the `div_clk` rise.
- **Latency.** Seed load and shift both take one edge. `o_lfsr_done` has zero latency.
- **Reset mid-operation.** All state clears immediately (asynchronously); phase restarts from 0.
- **`i_enable` low.** Counters and clocks continue running; the LFSR freezes. Any `step` pulses that occur while disabled are lost.
- **Seed request coinciding with `step`.** Seed load wins; that shift is dropped.

## Structure
- **Shared package `vga_clk_pkg`:**
  - `function lfsr_taps(int n)` returning a 32-bit tap mask;
  - default constants `PIX_HALF_DEF` and `SEED_DEF`.
- **Sub-module `half_period_div`** (parameter `HALF`): outputs the registered toggle and the pre-toggle pulse. Instantiated twice, once for pixel and once for div.
- The LFSR lives in the top block.

## Test plan
- **Divider timing.** `DIV_NUMBER=4`, `PIX_HALF=2`; release reset.
  - `div_clk` rises at edges 4, 12, 20 and falls at 8, 16.
  - `clk_pix` rises at edges 2, 6, 10.
- **LFSR sequence.** `NUM_BITS=4`, `i_enable=1`, no seed.
  - Successive steps give 0, 1, 3, 7, E, D, …
  - Returns to 0 after exactly 15 steps; 4'hF never appears.
- **Seed and done.** `i_seed_data=4'h9`, pulse `i_seed_dv` for one cycle between steps.
  - Data = 9 on the next edge and `o_lfsr_done=1`.
  - `o_lfsr_done` falls after the next step.
  - `o_lfsr_done` rises again after 15 steps.
- **Enable gating.** Hold `i_enable=0` across 3 `div_clk` periods.
  - LFSR value is unchanged; `div_clk` keeps toggling.
- **Seed-versus-step collision and mid-run reset.**
  - `i_seed_dv` asserted on the step cycle: seed value is loaded and no shift occurs.
  - Async `reset` pulsed mid-period: all outputs go to 0 without waiting for an edge.
- **Default width.** `NUM_BITS=25`, seed 30504031.
  - First step output equals `{seed[23:0], ~(seed[24]^seed[21])}`.

Source files
------------

// File: rtl/vga_clk_pkg.sv
// Shared constants and the maximal-length XNOR LFSR tap table.
package vga_clk_pkg;

  localparam int PIX_HALF_DEF = 2;
  localparam int SEED_DEF     = 30504031;

  // One-hot mask for a 1-indexed tap position.
  function automatic logic [31:0] tap(input int pos);
    return 32'd1 << (pos - 1);
  endfunction

  // Tap mask for widths 3..32; bit (k-1) set means tap k feeds the XNOR.
  function automatic logic [31:0] lfsr_taps(input int n);
    logic [31:0] m;
    m = '0;
    case (n)
      3:  m = tap(3)  | tap(2);
      4:  m = tap(4)  | tap(3);
      5:  m = tap(5)  | tap(3);
      6:  m = tap(6)  | tap(5);
      7:  m = tap(7)  | tap(6);
      8:  m = tap(8)  | tap(6)  | tap(5)  | tap(4);
      9:  m = tap(9)  | tap(5);
      10: m = tap(10) | tap(7);
      11: m = tap(11) | tap(9);
      12: m = tap(12) | tap(6)  | tap(4)  | tap(1);
      13: m = tap(13) | tap(4)  | tap(3)  | tap(1);
      14: m = tap(14) | tap(5)  | tap(3)  | tap(1);
      15: m = tap(15) | tap(14);
      16: m = tap(16) | tap(15) | tap(13) | tap(4);
      17: m = tap(17) | tap(14);
      18: m = tap(18) | tap(11);
      19: m = tap(19) | tap(6)  | tap(2)  | tap(1);
      20: m = tap(20) | tap(17);
      21: m = tap(21) | tap(19);
      22: m = tap(22) | tap(21);
      23: m = tap(23) | tap(18);
      24: m = tap(24) | tap(23) | tap(22) | tap(17);
      25: m = tap(25) | tap(22);
      26: m = tap(26) | tap(6)  | tap(2)  | tap(1);
      27: m = tap(27) | tap(5)  | tap(2)  | tap(1);
      28: m = tap(28) | tap(25);
      29: m = tap(29) | tap(27);
      30: m = tap(30) | tap(6)  | tap(4)  | tap(1);
      31: m = tap(31) | tap(28);
      32: m = tap(32) | tap(22) | tap(2)  | tap(1);
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_clk_rng_half_period_div.sv
// Half-period divider: toggles a registered clock every HALF input cycles and
// exposes the combinational pulse marking the cycle before each toggle.
module half_period_div #(
  parameter int HALF = 2
) (
  input  logic in_clk,
  input  logic reset,
  output logic tgl,
  output logic pulse
);

  // A counter of at least one bit keeps HALF=1 legal (toggle every cycle).
  localparam int            CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] LAST = CW'(HALF - 1);

  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;
  logic          tgl_reg;
  logic          tgl_next;

  assign pulse = (cnt_reg == LAST);
  assign tgl   = tgl_reg;

  // Wrap the counter and flip the output on the last cycle of each half-period.
  always_comb begin
    cnt_next = cnt_reg + 1'b1;
    tgl_next = tgl_reg;
    if (pulse) begin
      cnt_next = '0;
      tgl_next = ~tgl_reg;
    end
  end

  // Counter and toggle state; reset restarts the phase from zero.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
      tgl_reg <= 1'b0;
    end else begin
      cnt_reg <= cnt_next;
      tgl_reg <= tgl_next;
    end
  end

endmodule

// File: rtl/vga_clk_rng.sv
// Pixel clock, slow divided clock and a divided-clock-rate XNOR LFSR used for
// random maze wall bits. Everything runs in the in_clk domain.
module vga_clk_rng
  import vga_clk_pkg::*;
#(
  parameter int DIV_NUMBER = 50000,
  parameter int PIX_HALF   = PIX_HALF_DEF,
  parameter int NUM_BITS   = 25,
  parameter int SEED       = SEED_DEF
) (
  input  logic                in_clk,
  input  logic                reset,
  input  logic                i_enable,
  input  logic                i_seed_dv,
  input  logic [NUM_BITS-1:0] i_seed_data,
  output logic                clk_pix,
  output logic                div_clk,
  output logic [NUM_BITS-1:0] o_lfsr_data,
  output logic                o_lfsr_done
);

  // Reject unsupported widths/divisors and a tie-off seed that cannot fit.
  if ((NUM_BITS < 3) || (NUM_BITS > 32) || (DIV_NUMBER < 1) || (PIX_HALF < 1) ||
      (SEED < 0) || (longint'(SEED) >= (longint'(1) << NUM_BITS))) begin : g_bad_param
    $error("vga_clk_rng: unsupported parameter set");
  end

  localparam logic [31:0]         TAPS     = lfsr_taps(NUM_BITS);
  localparam logic [NUM_BITS-1:0] TAP_MASK = TAPS[NUM_BITS-1:0];

  logic                unused_pix_pulse;
  logic                div_pulse;
  logic                step;
  logic                fb;
  logic [NUM_BITS-1:0] shifted;
  logic [NUM_BITS-1:0] lfsr_reg;
  logic [NUM_BITS-1:0] lfsr_next;

  half_period_div #(.HALF(PIX_HALF)) u_pix_div (
    .in_clk (in_clk),
    .reset  (reset),
    .tgl    (clk_pix),
    .pulse  (unused_pix_pulse)
  );

  half_period_div #(.HALF(DIV_NUMBER)) u_slow_div (
    .in_clk (in_clk),
    .reset  (reset),
    .tgl    (div_clk),
    .pulse  (div_pulse)
  );

  // Step only on the wrap that precedes a div_clk rising edge, so the LFSR
  // update lands on the same edge as the rise.
  assign step = div_pulse & ~div_clk;

  // XNOR of the tap bits; all-ones is the lock-up state and is never left.
  assign fb = ~^(lfsr_reg & TAP_MASK);

  // Shift toward the MSB, feedback entering at bit 0.
  assign shifted[0] = fb;
  for (genvar gi = 1; gi < NUM_BITS; gi++) begin : g_shift
    assign shifted[gi] = lfsr_reg[gi-1];
  end

  // Seed load outranks a coincident step; otherwise hold.
  always_comb begin
    lfsr_next = lfsr_reg;
    if (i_enable && i_seed_dv) begin
      lfsr_next = i_seed_data;
    end else if (i_enable && step) begin
      lfsr_next = shifted;
    end
  end

  // LFSR state register, cleared to zero on reset.
  always_ff @(posedge in_clk or posedge reset) begin
    if (reset) begin
      lfsr_reg <= '0;
    end else begin
      lfsr_reg <= lfsr_next;
    end
  end

  assign o_lfsr_data = lfsr_reg;
  assign o_lfsr_done = (lfsr_reg == i_seed_data);

endmodule

// File: tb/tb_vga_clk_rng.sv
// Directed bench for vga_clk_rng: a 4-bit and a 25-bit instance share clock,
// reset and enable; expected LFSR values come from an independent tap model.
module tb_vga_clk_rng;

  logic        in_clk    = 1'b0;
  logic        reset     = 1'b1;
  logic        i_enable  = 1'b1;
  logic        seed_dv4  = 1'b0;
  logic        seed_dv25 = 1'b0;
  logic [3:0]  seed4     = 4'h0;
  logic [24:0] seed25    = 25'd30504031;

  logic        pix4, div4, done4;
  logic [3:0]  lfsr4;
  logic        pix25, div25, done25;
  logic [24:0] lfsr25;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [3:0]  m4;
  logic [24:0] m25;
  bit          ok;

  vga_clk_rng #(.DIV_NUMBER(4), .PIX_HALF(2), .NUM_BITS(4), .SEED(9)) dut4 (
    .in_clk(in_clk), .reset(reset), .i_enable(i_enable), .i_seed_dv(seed_dv4),
    .i_seed_data(seed4), .clk_pix(pix4), .div_clk(div4),
    .o_lfsr_data(lfsr4), .o_lfsr_done(done4)
  );

  vga_clk_rng #(.DIV_NUMBER(4), .PIX_HALF(2), .NUM_BITS(25), .SEED(30504031)) dut25 (
    .in_clk(in_clk), .reset(reset), .i_enable(i_enable), .i_seed_dv(seed_dv25),
    .i_seed_data(seed25), .clk_pix(pix25), .div_clk(div25),
    .o_lfsr_data(lfsr25), .o_lfsr_done(done25)
  );

  always #5 in_clk = ~in_clk;

  function automatic logic [3:0] next4(input logic [3:0] r);
    return {r[2:0], ~(r[3] ^ r[2])};
  endfunction

  function automatic logic [24:0] next25(input logic [24:0] r);
    return {r[23:0], ~(r[24] ^ r[21])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    $display("check %s obs=%0h exp=%0h", tag, obs, exp);
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for the next div_clk rising edge, sampled 1 ns after in_clk.
  task automatic wait_rise(output bit found);
    logic prev;
    found = 1'b0;
    prev  = div4;
    for (int i = 0; i < 40; i++) begin
      @(posedge in_clk);
      #1;
      if (!prev && div4) begin
        found = 1'b1;
        break;
      end
      prev = div4;
    end
  endtask

  // Pop the scoreboard at the next step edge and compare the selected LFSR.
  task automatic step_chk(input string tag, input bit sel25);
    bit          found;
    logic [31:0] exp;
    logic [31:0] obs;
    wait_rise(found);
    chk({tag, "_rise"}, {31'd0, found}, 32'd1);
    exp = exp_q.pop_front();
    obs = sel25 ? {7'd0, lfsr25} : {28'd0, lfsr4};
    chk(tag, obs, exp);
  endtask

  initial begin
    // Reset state while reset is asserted, before any clock edge.
    #3;
    chk("rst_pix", {31'd0, pix4}, 32'd0);
    chk("rst_div", {31'd0, div4}, 32'd0);
    chk("rst_lfsr", {28'd0, lfsr4}, 32'd0);
    chk("rst_done_zero_seed", {31'd0, done4}, 32'd1);
    chk("rst_lfsr25", {7'd0, lfsr25}, 32'd0);
    chk("rst_done25", {31'd0, done25}, 32'd0);

    // Divider timing and the first LFSR steps after release.
    @(negedge in_clk);
    reset = 1'b0;
    m4 = 4'h0;
    for (int n = 1; n <= 20; n++) begin
      @(posedge in_clk);
      #1;
      chk($sformatf("div_e%0d", n), {31'd0, div4}, 32'((n / 4) % 2));
      chk($sformatf("pix_e%0d", n), {31'd0, pix4}, 32'((n / 2) % 2));
      if ((n % 8) == 4) begin
        m4 = next4(m4);
        exp_q.push_back({28'd0, m4});
        chk($sformatf("lfsr_e%0d", n), {28'd0, lfsr4}, exp_q.pop_front());
      end
    end

    // Remaining steps of the full 15-step period; lock-up value never seen.
    for (int k = 4; k <= 15; k++) begin
      m4 = next4(m4);
      exp_q.push_back({28'd0, m4});
      step_chk($sformatf("seq_s%0d", k), 1'b0);
      chk($sformatf("no_lockup_s%0d", k), {31'd0, (lfsr4 == 4'hF)}, 32'd0);
    end
    chk("period15_back_to_0", {28'd0, lfsr4}, 32'd0);

    // Seed load between steps and the done flag over a full period.
    seed4 = 4'h9;
    #1;
    chk("done_before_seed", {31'd0, done4}, 32'd0);
    seed_dv4 = 1'b1;
    @(posedge in_clk);
    #1;
    seed_dv4 = 1'b0;
    m4 = 4'h9;
    chk("seed_loaded", {28'd0, lfsr4}, 32'h9);
    chk("done_after_seed", {31'd0, done4}, 32'd1);
    for (int k = 1; k <= 15; k++) begin
      m4 = next4(m4);
      exp_q.push_back({28'd0, m4});
      step_chk($sformatf("seed_s%0d", k), 1'b0);
      if (k < 15) chk($sformatf("done_low_s%0d", k), {31'd0, done4}, 32'd0);
    end
    chk("done_after_15", {31'd0, done4}, 32'd1);

    // Enable gating: LFSR freezes while div_clk keeps rising.
    i_enable = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      wait_rise(ok);
      chk($sformatf("gate_rise%0d", k), {31'd0, ok}, 32'd1);
      chk($sformatf("gate_hold%0d", k), {28'd0, lfsr4}, {28'd0, m4});
    end
    i_enable = 1'b1;
    m4 = next4(m4);
    exp_q.push_back({28'd0, m4});
    step_chk("resume_step", 1'b0);

    // Seed request on the step cycle: load wins, the shift is dropped.
    repeat (7) @(posedge in_clk);
    #1;
    seed4    = 4'h5;
    seed_dv4 = 1'b1;
    @(posedge in_clk);
    #1;
    seed_dv4 = 1'b0;
    chk("coll_on_rise", {31'd0, div4}, 32'd1);
    chk("coll_seed_wins", {28'd0, lfsr4}, 32'h5);
    chk("coll_done", {31'd0, done4}, 32'd1);
    m4 = next4(4'h5);
    exp_q.push_back({28'd0, m4});
    step_chk("coll_next_step", 1'b0);

    // Asynchronous reset between edges clears everything immediately.
    @(posedge in_clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_lfsr", {28'd0, lfsr4}, 32'd0);
    chk("async_div", {31'd0, div4}, 32'd0);
    chk("async_pix", {31'd0, pix4}, 32'd0);
    chk("async_lfsr25", {7'd0, lfsr25}, 32'd0);
    chk("async_done", {31'd0, done4}, 32'd0);
    @(negedge in_clk);
    reset = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(posedge in_clk);
      #1;
      chk($sformatf("restart_div_e%0d", n), {31'd0, div4}, 32'(n == 4));
    end

    // Default 25-bit width: seed, then one step.
    seed_dv25 = 1'b1;
    @(posedge in_clk);
    #1;
    seed_dv25 = 1'b0;
    chk("seed25_loaded", {7'd0, lfsr25}, {7'd0, seed25});
    chk("done25_seeded", {31'd0, done25}, 32'd1);
    m25 = next25(seed25);
    exp_q.push_back({7'd0, m25});
    step_chk("step25", 1'b1);
    chk("done25_after_step", {31'd0, done25}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
